// File: rtl/tlb_maint_seq_if.sv
// tlb_maint_seq_if: MEM-stage request/response and TLB array access signals for the maintenance sequencer
interface tlb_maint_seq_if #(parameter int TLBNUMSIZE = 4);
  logic                  flush;
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [2:0]            req_invop;
  logic [9:0]            req_asid;
  logic [18:0]           req_vppn;
  logic [TLBNUMSIZE-1:0] req_index;
  logic [TLBNUMSIZE-1:0] tlb_rd_idx;
  logic                  tlb_rd_e;
  logic                  tlb_rd_g;
  logic [9:0]            tlb_rd_asid;
  logic [5:0]            tlb_rd_ps;
  logic [18:0]           tlb_rd_vppn;
  logic                  tlb_clr_en;
  logic                  tlb_wr_en;
  logic [TLBNUMSIZE-1:0] tlb_wr_idx;
  logic                  done_valid;
  logic                  done_ne;
  logic [TLBNUMSIZE-1:0] done_index;
  logic                  done_ine;
  modport slave (
    input  flush, req_valid, req_op, req_invop, req_asid, req_vppn, req_index,
           tlb_rd_e, tlb_rd_g, tlb_rd_asid, tlb_rd_ps, tlb_rd_vppn,
    output req_ready, tlb_rd_idx, tlb_clr_en, tlb_wr_en, tlb_wr_idx,
           done_valid, done_ne, done_index, done_ine
  );
  modport master (
    output flush, req_valid, req_op, req_invop, req_asid, req_vppn, req_index,
           tlb_rd_e, tlb_rd_g, tlb_rd_asid, tlb_rd_ps, tlb_rd_vppn,
    input  req_ready, tlb_rd_idx, tlb_clr_en, tlb_wr_en, tlb_wr_idx,
           done_valid, done_ne, done_index, done_ine
  );
endinterface

// File: rtl/tlb_maint_seq.sv
// tlb_maint_seq: sequences TLBSRCH/RD/WR/FILL/INVTLB against the TLB array, one entry scanned per cycle
module tlb_maint_seq #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = $clog2(TLBNUM)
) (
  input logic aclk,
  input logic aresetn,
  tlb_maint_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  state_t state, state_n;
  logic [TLBNUMSIZE-1:0] ptr, fill_cnt, lat_idx, res_idx;
  logic [2:0] lat_op, lat_invop;
  logic [9:0] lat_asid;
  logic [18:0] lat_vppn;
  logic res_ne, res_ine;
  logic accept, scan_op, last, amatch, vmatch, hit, inv_cond, resp, wr;
  assign accept   = bus.req_valid && state == IDLE && !bus.flush;
  assign scan_op  = bus.req_op == 3'd0 || (bus.req_op == 3'd4 && bus.req_invop != 3'd7);
  assign last     = ptr == TLBNUMSIZE'(TLBNUM - 1);
  assign amatch   = bus.tlb_rd_asid == lat_asid;
  assign vmatch   = bus.tlb_rd_ps == 6'd21 ? bus.tlb_rd_vppn[18:9] == lat_vppn[18:9]
                                           : bus.tlb_rd_vppn == lat_vppn;
  assign hit      = bus.tlb_rd_e && (bus.tlb_rd_g || amatch) && vmatch;
  assign inv_cond = lat_invop < 3'd2  ? 1'b1 :
                    lat_invop == 3'd2 ? bus.tlb_rd_g :
                    lat_invop == 3'd3 ? !bus.tlb_rd_g :
                    lat_invop == 3'd4 ? !bus.tlb_rd_g && amatch :
                    lat_invop == 3'd5 ? !bus.tlb_rd_g && amatch && vmatch :
                    lat_invop == 3'd6 ? (bus.tlb_rd_g || amatch) && vmatch : 1'b0;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? (scan_op ? SCAN : RESP) : IDLE) :
              state == SCAN ? (bus.flush ? IDLE :
                               (last || (lat_op == 3'd0 && hit)) ? RESP : SCAN) : IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  // A flush in RESP suppresses both the completion and the write strobe
  assign resp           = state == RESP && !bus.flush;
  assign wr             = resp && (lat_op == 3'd2 || lat_op == 3'd3);
  assign bus.req_ready  = state == IDLE;
  assign bus.tlb_rd_idx = state == SCAN ? ptr : (resp && lat_op == 3'd1) ? lat_idx : '0;
  assign bus.tlb_clr_en = state == SCAN && !bus.flush && lat_op == 3'd4 && bus.tlb_rd_e && inv_cond;
  assign bus.tlb_wr_en  = wr;
  assign bus.tlb_wr_idx = wr ? lat_idx : '0;
  assign bus.done_valid = resp;
  assign bus.done_ne    = resp && res_ne;
  assign bus.done_index = resp ? res_idx : '0;
  assign bus.done_ine   = resp && res_ine;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      ptr       <= '0;
      fill_cnt  <= '0;
      lat_idx   <= '0;
      res_idx   <= '0;
      lat_op    <= '0;
      lat_invop <= '0;
      lat_asid  <= '0;
      lat_vppn  <= '0;
      res_ne    <= 1'b0;
      res_ine   <= 1'b0;
    end else begin
      fill_cnt <= fill_cnt + 1'b1;
      ptr      <= accept ? '0 : state == SCAN ? ptr + 1'b1 : ptr;
      if (accept) begin
        lat_op    <= bus.req_op;
        lat_invop <= bus.req_invop;
        lat_asid  <= bus.req_asid;
        lat_vppn  <= bus.req_vppn;
        lat_idx   <= bus.req_op == 3'd3 ? fill_cnt : bus.req_index;
        res_idx   <= bus.req_op == 3'd1 ? bus.req_index : '0;
        res_ne    <= 1'b0;
        res_ine   <= bus.req_op > 3'd4 || (bus.req_op == 3'd4 && bus.req_invop == 3'd7);
      end else if (state == SCAN && lat_op == 3'd0) begin
        if (hit)       res_idx <= ptr;
        else if (last) res_ne  <= 1'b1;
      end
    end
endmodule

// File: doc/tlb_maint_seq.md
Name: tlb_maint_seq

Overview:
- Sequences all TLB maintenance ops (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) against the TLBNUM-entry TLB array.
- Sits between the MEM stage and the TLB array; the MEM stage holds the instruction until done_valid.
- Scans the array one entry per cycle through the array's combinational compare-item read port, and drives per-entry clear and write strobes.

Parameters:
TLBNUM, 16, number of TLB entries (power of 2)
TLBNUMSIZE, $clog2(TLBNUM), index width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
flush  in  1  abort the current op (exception/ertn in a later stage)
req_valid  in  1  op request from MEM stage
req_ready  out  1  high only in IDLE
req_op  in  3  0=SRCH 1=RD 2=WR 3=FILL 4=INV; 5-7 reserved
req_invop  in  3  INVTLB op code (CLEAR_ALL0..CLEAR_G1_OR_ASID_AND_VA)
req_asid  in  10  ASID (CSR.ASID for SRCH, rj for INV)
req_vppn  in  19  VA[31:13] (CSR.TLBEHI for SRCH, rk for INV)
req_index  in  TLBNUMSIZE  CSR.TLBIDX index, used by RD/WR
tlb_rd_idx  out  TLBNUMSIZE  array read index
tlb_rd_e, tlb_rd_g  in  1 each  E and G of the read entry
tlb_rd_asid  in  10  entry ASID
tlb_rd_ps  in  6  entry PS (12 or 21)
tlb_rd_vppn  in  19  entry VPPN
tlb_clr_en  out  1  clear E of entry tlb_rd_idx this cycle
tlb_wr_en  out  1  write CSR-staged entry
tlb_wr_idx  out  TLBNUMSIZE  write index
done_valid  out  1  one-cycle completion pulse
done_ne  out  1  SRCH miss
done_index  out  TLBNUMSIZE  SRCH hit index or RD index
done_ine  out  1  invalid INVTLB op / reserved req_op

Behaviour:
- Reset: state=IDLE, ptr=0, fill_cnt=0. All outputs are 0 except req_ready=1.
- fill_cnt: free-running counter, increments every aclk and wraps at TLBNUM-1 -> 0. FILL uses the value sampled at the accept cycle.
- Accept: a request is accepted when req_valid && req_ready && !flush. The request fields are latched.
- States: IDLE, SCAN, RESP.
- RD/WR/FILL/reserved ops: IDLE -> RESP.
  - WR/FILL: tlb_wr_en=1 for exactly the RESP cycle; tlb_wr_idx = latched index (WR) or latched fill_cnt (FILL).
  - RD: tlb_rd_idx = index; done_index = index.
  - Reserved ops (5-7): done_ine=1 and no side effects.
- SRCH/INV: IDLE -> SCAN with ptr=0; tlb_rd_idx=ptr; ptr advances 1 per cycle.
- Match terms:
  - vmatch: PS==12 compares vppn[18:0]; PS==21 compares vppn[18:9].
  - amatch: asid equal.
- SRCH:
  - Hit condition: E && (G || amatch) && vmatch.
  - First hit -> RESP with done_index=ptr, done_ne=0.
  - If ptr==TLBNUM-1 with no hit -> RESP with done_ne=1, done_index=0.
  - Latency from accept: hit at entry k gives done at cycle k+2; a miss gives TLBNUM+1.
- INV: all TLBNUM entries are scanned; tlb_clr_en=E && cond in the same cycle. cond by invop:
  - 0,1: always
  - 2: G
  - 3: !G
  - 4: !G && amatch
  - 5: !G && amatch && vmatch
  - 6: (G || amatch) && vmatch
  - invop 7: no scan; IDLE -> RESP with done_ine=1.
  - INV completes at TLBNUM+1 cycles.
- RESP: done_valid=1 for one cycle, then -> IDLE. done_* are valid only while done_valid=1 and are held at 0 otherwise.
- flush:
  - In SCAN or RESP: go to IDLE next cycle; no done_valid and no wr_en. Clears already issued by INV remain.
  - In IDLE: blocks accept.
- Ptr wrap: ptr resets to 0 on every accept; it never wraps within an op.
- Reset mid-op: immediate return to the reset state; no strobe may be asserted during reset.

Test Plan:
1. SRCH, entry 5 = {E=1,G=0,asid=3,PS=12,vppn=0x1234}, req asid=3 vppn=0x1234 -> done_valid 7 cycles after accept, done_index=5, done_ne=0; no clr/wr strobes.
2. SRCH with asid=4 against the same table (G=0) -> done_ne=1 at cycle 17; set entry 5 G=1 and repeat -> hit at index 5. PS=21 entry with vppn=0x1200, req vppn=0x1234 -> hit.
3. INV invop=2, entries 1,7 G=1 and others G=0 -> tlb_clr_en pulses exactly at ptr=1 and ptr=7; done at cycle 17. invop=7 -> done_ine=1 after 1 cycle, zero clears.
4. WR index=9 -> single tlb_wr_en with idx=9. Two FILLs accepted 3 cycles apart -> wr_idx values differ by 3 mod 16.
5. INV invop=0 flushed at scan cycle 4 -> clears only at ptr<=3, no done_valid, req_ready=1 the next cycle. A new SRCH accepted immediately after starts at ptr=0.
6. aresetn asserted mid-SRCH -> all outputs 0 and req_ready=1 immediately; fill_cnt=0 after release.
